// File: rtl/branch_predictor_bht_if.sv
// ==========================================================================
// branch_predictor_bht_if : IF-lookup / EX-training bus for the BHT | rev 1.0
// ==========================================================================
`default_nettype none

interface branch_predictor_bht_if;
  logic [31:0] if_pc;
  logic [31:0] if_ir;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic        ex_predicted;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        is_branch;
  logic [15:0] br_count;
  logic [15:0] mis_count;

  modport master (
    output if_pc, if_ir, ex_valid, ex_pc, ex_taken, ex_predicted,
    input  predict_taken, predict_target, is_branch, br_count, mis_count
  );

  modport slave (
    input  if_pc, if_ir, ex_valid, ex_pc, ex_taken, ex_predicted,
    output predict_taken, predict_target, is_branch, br_count, mis_count
  );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_bht.sv
// ==========================================================================
// branch_predictor_bht : direct-mapped 2-bit counter branch predictor | rev 1.0
// ==========================================================================
`default_nettype none

module branch_predictor_bht #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  branch_predictor_bht_if.slave  bus
);

  localparam logic [1:0]  c_CNT_WNT  = 2'b01;
  localparam logic [1:0]  c_CNT_MAX  = 2'b11;
  localparam logic [1:0]  c_CNT_MIN  = 2'b00;
  localparam logic [15:0] c_STAT_MAX = 16'hFFFF;
  localparam logic [5:0]  c_OP_BEQ   = 6'b000100;
  localparam logic [5:0]  c_OP_J     = 6'b000010;

  logic [1:0]  table_q [ENTRIES];
  logic [1:0]  table_d [ENTRIES];
  logic [15:0] br_count_q, br_count_d;
  logic [15:0] mis_count_q, mis_count_d;

  logic [IDX_W-1:0] w_ex_idx;
  logic [IDX_W-1:0] w_if_idx;
  logic [5:0]       w_opcode;
  logic [31:0]      w_pc_plus4;
  logic [31:0]      w_br_offset;
  logic             w_unused;

  assign w_ex_idx    = bus.ex_pc[IDX_W+1:2];
  assign w_if_idx    = bus.if_pc[IDX_W+1:2];
  assign w_opcode    = bus.if_ir[31:26];
  assign w_pc_plus4  = bus.if_pc + 32'd4;
  assign w_br_offset = {{14{bus.if_ir[15]}}, bus.if_ir[15:0], 2'b00};
  // Untagged table: only the index bits of the resolved PC matter.
  assign w_unused    = &{1'b0, bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};

  always_comb begin
    table_d     = table_q;
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (bus.ex_valid) begin
      if (bus.ex_taken) begin
        if (table_q[w_ex_idx] != c_CNT_MAX) table_d[w_ex_idx] = table_q[w_ex_idx] + 2'd1;
      end else begin
        if (table_q[w_ex_idx] != c_CNT_MIN) table_d[w_ex_idx] = table_q[w_ex_idx] - 2'd1;
      end
      if (br_count_q != c_STAT_MAX) br_count_d = br_count_q + 16'd1;
      if ((bus.ex_taken != bus.ex_predicted) && (mis_count_q != c_STAT_MAX))
        mis_count_d = mis_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= c_CNT_WNT;
      br_count_q  <= 16'd0;
      mis_count_q <= 16'd0;
    end else begin
      table_q     <= table_d;
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  always_comb begin
    bus.is_branch      = 1'b0;
    bus.predict_taken  = 1'b0;
    bus.predict_target = w_pc_plus4;
    case (w_opcode)
      c_OP_BEQ: begin
        bus.is_branch      = 1'b1;
        bus.predict_taken  = table_q[w_if_idx][1];
        bus.predict_target = w_pc_plus4 + w_br_offset;
      end
      c_OP_J: begin
        bus.is_branch      = 1'b1;
        bus.predict_taken  = 1'b1;
        bus.predict_target = {w_pc_plus4[31:28], bus.if_ir[25:0], 2'b00};
      end
      default: ;
    endcase
  end

  assign bus.br_count  = br_count_q;
  assign bus.mis_count = mis_count_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
// ==========================================================================
// tb_branch_predictor_bht : scoreboard bench for branch_predictor_bht | rev 1.0
// ==========================================================================
`default_nettype none

module tb_branch_predictor_bht;

  localparam logic [31:0] c_BEQ16  = 32'h11000010;
  localparam logic [31:0] c_BEQNEG = 32'h1100FFFF;
  localparam logic [31:0] c_J6     = 32'h08000006;
  localparam logic [31:0] c_SLT    = 32'h0013A02A;

  typedef struct packed {
    logic        ib;
    logic        pt;
    logic [31:0] tgt;
    logic [15:0] br;
    logic [15:0] mis;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  exp_t  exp_q  [$];
  string name_q [$];

  branch_predictor_bht_if bus_if ();

  branch_predictor_bht #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ir, input logic exv,
                       input logic [31:0] expc, input logic ext, input logic expr);
    bus_if.if_pc        = pc;
    bus_if.if_ir        = ir;
    bus_if.ex_valid     = exv;
    bus_if.ex_pc        = expc;
    bus_if.ex_taken     = ext;
    bus_if.ex_predicted = expr;
  endtask

  task automatic expect_out(input string nm, input logic ib, input logic pt,
                            input logic [31:0] tgt, input logic [15:0] br, input logic [15:0] mis);
    exp_t e;
    e.ib = ib; e.pt = pt; e.tgt = tgt; e.br = br; e.mis = mis;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares combinational outputs mid-cycle against queued expectations.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.ib  = bus_if.is_branch;
        a.pt  = bus_if.predict_taken;
        a.tgt = bus_if.predict_target;
        a.br  = bus_if.br_count;
        a.mis = bus_if.mis_count;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got ib=%0b pt=%0b tgt=%h br=%0d mis=%0d, want ib=%0b pt=%0b tgt=%h br=%0d mis=%0d",
                   nm, a.ib, a.pt, a.tgt, a.br, a.mis, e.ib, e.pt, e.tgt, e.br, e.mis);
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    drive(32'd16, c_BEQ16, 1'b0, 32'd0, 1'b0, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;

    expect_out("reset_beq", 1'b1, 1'b0, 32'd84, 16'd0, 16'd0);
    cyc();

    // Two taken updates; each presented cycle sees the pre-update counter.
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b1, 1'b0);
    expect_out("upd1_nobypass", 1'b1, 1'b0, 32'd84, 16'd0, 16'd0);
    cyc();
    expect_out("upd2_cnt10", 1'b1, 1'b1, 32'd84, 16'd1, 16'd1);
    cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("after_upd2_cnt11", 1'b1, 1'b1, 32'd84, 16'd2, 16'd2);
    cyc();

    // Not-taken walk down from 11.
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b0, 1'b1);
    cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("nt1_cnt10", 1'b1, 1'b1, 32'd84, 16'd3, 16'd3);
    cyc();
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b0, 1'b1);
    cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("nt2_cnt01", 1'b1, 1'b0, 32'd84, 16'd4, 16'd4);
    cyc();
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("nt6_hold00", 1'b1, 1'b0, 32'd84, 16'd8, 16'd4);
    cyc();
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b1, 1'b0);
    cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("t_from00_cnt01", 1'b1, 1'b0, 32'd84, 16'd9, 16'd5);
    cyc();
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b1, 1'b0);
    cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("t_cnt10", 1'b1, 1'b1, 32'd84, 16'd10, 16'd6);
    cyc();
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b1, 1'b1);
    cyc();

    // Counter for index 4 is now 11: PC 80 aliases, PC 20 is untouched.
    drive(32'd80, c_BEQ16, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("alias_pc80", 1'b1, 1'b1, 32'd148, 16'd11, 16'd6);
    cyc();
    drive(32'd20, c_BEQ16, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("other_idx_pc20", 1'b1, 1'b0, 32'd88, 16'd11, 16'd6);
    cyc();
    drive(32'd76, c_J6, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("jump", 1'b1, 1'b1, 32'd24, 16'd11, 16'd6);
    cyc();
    drive(32'd76, c_SLT, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("slt_nonbranch", 1'b0, 1'b0, 32'd80, 16'd11, 16'd6);
    cyc();
    drive(32'd0, c_BEQNEG, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("beq_neg_offset", 1'b1, 1'b0, 32'd0, 16'd11, 16'd6);
    cyc();
    drive(32'hFFFF_FFFC, c_BEQ16, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("beq_wrap", 1'b1, 1'b0, 32'h0000_0040, 16'd11, 16'd6);
    cyc();
    drive(32'hFFFF_FFF8, c_J6, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("jump_region", 1'b1, 1'b1, 32'hF000_0018, 16'd11, 16'd6);
    cyc();

    // Statistics saturation.
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b1, 1'b0);
    for (int i = 0; i < 65540; i++) cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("stats_saturate", 1'b1, 1'b1, 32'd84, 16'hFFFF, 16'hFFFF);
    cyc();
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b1, 1'b0);
    cyc();
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("stats_hold", 1'b1, 1'b1, 32'd84, 16'hFFFF, 16'hFFFF);
    cyc();

    // Reset with a concurrent update: the update must be discarded.
    rst = 1'b0;
    drive(32'd16, c_BEQ16, 1'b1, 32'd16, 1'b1, 1'b0);
    cyc();
    rst = 1'b1;
    drive(32'd16, c_BEQ16, 1'b0, 32'd16, 1'b0, 1'b0);
    expect_out("reset_clears", 1'b1, 1'b0, 32'd84, 16'd0, 16'd0);
    cyc();
    drive(32'd76, c_J6, 1'b0, 32'd0, 1'b0, 1'b0);
    expect_out("reset_jump", 1'b1, 1'b1, 32'd24, 16'd0, 16'd0);
    cyc();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
